// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes, opcodes and
// datapath mux/ALU selector codes.
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ORIEX  = 4'd10;
  localparam logic [3:0] S_IMMWB  = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_TRAP   = 2'b11;

endpackage

// File: rtl/mc_wait_ctr.sv
// Memory wait-state counter shared by all memory-access states; done marks the final
// cycle of an access.
module mc_wait_ctr #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic done
);

  localparam int unsigned CW = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);

  logic [CW-1:0] cnt;

  assign done = (cnt == CW'(MEM_WAIT));

  // Clearing on done also clears on leaving the state, since the state only moves on done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (active && !done) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath with Moore outputs per state.
// Define MC_ILLEGAL_TRAP_EN to route unknown opcodes to a trap state instead of a no-op.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned OP_W     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            ext_zero,
  output logic [1:0]      pc_src,
  output logic            illegal_op,
  output logic [3:0]      state
);

  logic [3:0] state_q;
  logic       ori_q;
  logic       mem_active;
  logic       mem_done;

  assign state      = state_q;
  assign mem_active = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mc_wait_ctr #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .active(mem_active),
    .done  (mem_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ori_q   <= 1'b0;
    end else begin
      // IMMWB is only ever entered from ADDIEX or ORIEX, so this flag tracks which one.
      ori_q <= (state_q == S_ORIEX);
      case (state_q)
        S_FETCH:  if (mem_done) state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_W'(OP_LW), OP_W'(OP_SW): state_q <= S_MEMADR;
            OP_W'(OP_RTYPE):            state_q <= S_EXEC;
            OP_W'(OP_BEQ):              state_q <= S_BRANCH;
            OP_W'(OP_ADDI):             state_q <= S_ADDIEX;
            OP_W'(OP_ORI):              state_q <= S_ORIEX;
            OP_W'(OP_J):                state_q <= S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
            default:                    state_q <= S_TRAP;
`else
            default:                    state_q <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR: state_q <= (op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_done) state_q <= S_MEMWB;
        S_MEMWR:  if (mem_done) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_ALUWB;
        S_ADDIEX: state_q <= S_IMMWB;
        S_ORIEX:  state_q <= S_IMMWB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    ext_zero      = 1'b0;
    pc_src        = PC_ALU;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_done;
        pc_write  = mem_done;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OR;
        ext_zero  = 1'b1;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        ext_zero  = ori_q;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        pc_write   = 1'b1;
        pc_src     = PC_TRAP;
        illegal_op = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (MEM_WAIT 0 and 2), a cycle-count table,
// and a per-cycle reference model driven by directed and random instruction streams.
module tb_multicycle_control;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    int         k;
    logic [5:0] op;
    int         cycles;
  } vec_t;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam int ILL_BASE = 3;
  localparam bit TRAP_ON  = 1'b1;
`else
  localparam int ILL_BASE = 2;
  localparam bit TRAP_ON  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_v [2];
  logic [5:0] op_v  [2];
  ctl_t       obs   [2];
  int         n_checks = 0;
  int         n_fail   = 0;
  ctl_t       expq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] state;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;

    multicycle_control #(
      .MEM_WAIT(g * 2),
      .OP_W    (6)
    ) u_dut (
      .clk          (clk),
      .rst          (rst_v[g]),
      .op           (op_v[g]),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .i_or_d       (i_or_d),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .ir_write     (ir_write),
      .mem_to_reg   (mem_to_reg),
      .reg_dst      (reg_dst),
      .reg_write    (reg_write),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .ext_zero     (ext_zero),
      .pc_src       (pc_src),
      .illegal_op   (illegal_op),
      .state        (state)
    );

    assign obs[g] = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, ext_zero,
                     pc_src, illegal_op};
  end

  task automatic check(input string nm, input ctl_t got, input ctl_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Expected control word for one cycle of a given phase.
  function automatic ctl_t exp_ctl(input int ph, input bit last, input bit ori);
    ctl_t c;
    c       = '0;
    c.state = 4'(ph);
    case (ph)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = last; c.pc_write = last; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.i_or_d = 1; end
      4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      5:  begin c.mem_write = 1; c.i_or_d = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_src = 2'b01; end
      9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; c.ext_zero = 1; end
      11: begin c.reg_write = 1; c.ext_zero = ori; end
      12: begin c.pc_write = 1; c.pc_src = 2'b10; end
      13: begin c.pc_write = 1; c.pc_src = 2'b11; c.illegal_op = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic void push(input int ph, input bit last, input bit ori);
    expq.push_back(exp_ctl(ph, last, ori));
  endfunction

  // Whole-instruction expected trace: memory phases stretched to w+1 cycles.
  function automatic void build(input logic [5:0] opc, input int w);
    expq.delete();
    for (int i = 0; i < w; i++) push(0, 0, 0);
    push(0, 1, 0);
    push(1, 0, 0);
    case (opc)
      OP_LW:    begin push(2, 0, 0); for (int i = 0; i <= w; i++) push(3, 0, 0); push(4, 0, 0); end
      OP_SW:    begin push(2, 0, 0); for (int i = 0; i <= w; i++) push(5, 0, 0); end
      OP_RTYPE: begin push(6, 0, 0); push(7, 0, 0); end
      OP_BEQ:   push(8, 0, 0);
      OP_J:     push(12, 0, 0);
      OP_ADDI:  begin push(9, 0, 0); push(11, 0, 0); end
      OP_ORI:   begin push(10, 0, 0); push(11, 0, 1); end
      default:  if (TRAP_ON) push(13, 0, 0);
    endcase
  endfunction

  // Entered in the low phase of the instruction's first cycle; leaves in the next one's.
  task automatic run_instr(input int k, input logic [5:0] opc, input string nm);
    build(opc, k * 2);
    for (int i = 0; i < expq.size(); i++) begin
      check($sformatf("%s[%0d]", nm, i), obs[k], expq[i]);
      if (i == 0) op_v[k] = opc;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic measure(input int k, input logic [5:0] opc, input int expc);
    int n = 0;
    op_v[k] = opc;
    while (obs[k].state == 4'd0 && n < 50) begin n++; @(negedge clk); #1; end
    while (obs[k].state != 4'd0 && n < 50) begin n++; @(negedge clk); #1; end
    check_int($sformatf("cycles_k%0d_op%b", k, opc), n, expc);
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    rst_v[k] = 1'b1;
    #1;
    check($sformatf("reset_k%0d", k), obs[k], exp_ctl(0, k == 0, 0));
    @(negedge clk);
    rst_v[k] = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vt[15];
    logic [5:0] legal[7];
    logic [5:0] opc;
    logic [31:0] rv;
    int          r;

    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;
    op_v[0]  = 6'd0;
    op_v[1]  = 6'd0;
    legal    = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J};

    vt[0]  = '{0, OP_LW, 5};     vt[1]  = '{0, OP_SW, 4};
    vt[2]  = '{0, OP_RTYPE, 4};  vt[3]  = '{0, OP_BEQ, 3};
    vt[4]  = '{0, OP_J, 3};      vt[5]  = '{0, OP_ADDI, 4};
    vt[6]  = '{0, OP_ORI, 4};    vt[7]  = '{0, 6'h3f, ILL_BASE};
    vt[8]  = '{1, OP_LW, 9};     vt[9]  = '{1, OP_SW, 8};
    vt[10] = '{1, OP_RTYPE, 6};  vt[11] = '{1, OP_BEQ, 5};
    vt[12] = '{1, OP_J, 5};      vt[13] = '{1, OP_ORI, 6};
    vt[14] = '{1, 6'h3f, ILL_BASE + 2};

    for (int i = 0; i < 15; i++) begin
      do_reset(vt[i].k);
      measure(vt[i].k, vt[i].op, vt[i].cycles);
    end

    do_reset(0);
    run_instr(0, OP_LW, "lw_w0");
    run_instr(0, OP_RTYPE, "rtype_w0");
    run_instr(0, OP_BEQ, "beq_w0");
    run_instr(0, OP_J, "j_w0");
    run_instr(0, OP_ORI, "ori_w0");
    run_instr(0, 6'h3f, "illegal_w0");
    run_instr(0, OP_ADDI, "addi_w0");

    do_reset(1);
    run_instr(1, OP_SW, "sw_w2");
    run_instr(1, 6'h3f, "illegal_w2");

    // Asynchronous reset in the middle of a load's memory read.
    do_reset(1);
    op_v[1] = OP_LW;
    repeat (5) begin @(negedge clk); #1; end
    check_int("in_memrd", int'(obs[1].state), 3);
    #2;
    rst_v[1] = 1'b1;
    #1;
    check("async_rst_memrd", obs[1], exp_ctl(0, 0, 0));
    repeat (2) begin
      @(posedge clk);
      #1;
      check("held_in_rst", obs[1], exp_ctl(0, 0, 0));
    end
    @(negedge clk);
    rst_v[1] = 1'b0;
    #1;
    run_instr(1, OP_LW, "lw_after_rst");

    for (int k = 0; k < 2; k++) begin
      do_reset(k);
      for (int n = 0; n < 25; n++) begin
        r = $urandom_range(0, 7);
        if (r < 7) begin
          opc = legal[r];
        end else begin
          rv  = $urandom();
          opc = rv[5:0];
        end
        run_instr(k, opc, $sformatf("rand_k%0d_n%0d", k, n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
